// File: rtl/bit_stuffer_ser.sv
// Parametrised USB-style TX serialiser: 1-deep holding register, LSB-first shifting,
// bit stuffing after STUFF_LIMIT raw ones (across word boundaries) and optional NRZI line coding.
module bit_stuffer_ser #(
    parameter int DATA_W      = 8,
    parameter int BIT_PERIOD  = 8,
    parameter int STUFF_LIMIT = 6,
    parameter bit NRZI_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              serial_out,
    output logic              stuffing,
    output logic              bit_strobe,
    output logic              busy
);

    localparam int TW = $clog2(BIT_PERIOD);
    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] STUFF = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pendFull_q, pendFull_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IW-1:0]     bitIdx_q, bitIdx_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [OW-1:0]     ones_q, ones_d;
    logic              stuffPend_q, stuffPend_d;
    logic              serial_q, serial_d;
    logic              stuffing_q, stuffing_d;
    logic              strobe_q, strobe_d;

    logic              tick, advance, load, startData, startStuff, goIdle, dataBit;
    logic [OW-1:0]     onesNext;
    logic [DATA_W-1:0] shifted;

    // Each tick picks exactly one successor: stuff bit, next data bit, next word, or idle.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pendFull_d  = pendFull_q;
        shift_d     = shift_q;
        bitIdx_d    = bitIdx_q;
        timer_d     = timer_q;
        ones_d      = ones_q;
        stuffPend_d = stuffPend_q;
        serial_d    = serial_q;
        stuffing_d  = stuffing_q;
        strobe_d    = 1'b0;
        tick        = (timer_q == TW'(BIT_PERIOD - 1));
        shifted     = shift_q >> 1;
        advance     = 1'b0;
        load        = 1'b0;
        startStuff  = 1'b0;
        goIdle      = 1'b0;
        dataBit     = 1'b0;
        onesNext    = '0;

        if (data_valid && !pendFull_q) begin
            pendFull_d = 1'b1;
            pend_d     = data_in;
        end

        case (state_q)
            IDLE: begin
                if (pendFull_q) load = 1'b1;
            end
            DATA, STUFF: begin
                timer_d = tick ? '0 : timer_q + 1'b1;
                if (tick) begin
                    if (state_q == DATA && stuffPend_q) startStuff = 1'b1;
                    else if (bitIdx_q < IW'(DATA_W - 1)) advance = 1'b1;
                    else if (pendFull_q) load = 1'b1;
                    else goIdle = 1'b1;
                end
            end
            default: goIdle = 1'b1;
        endcase

        if (advance) begin
            shift_d  = shifted;
            bitIdx_d = bitIdx_q + 1'b1;
            dataBit  = shifted[0];
        end
        if (load) begin
            shift_d    = pend_q;
            bitIdx_d   = '0;
            timer_d    = '0;
            pendFull_d = 1'b0;
            dataBit    = pend_q[0];
        end
        startData = advance || load;

        // The ones run is counted on raw bits, so it carries straight across word boundaries.
        if (startData) begin
            onesNext    = dataBit ? ones_q + 1'b1 : '0;
            ones_d      = onesNext;
            stuffPend_d = (onesNext == OW'(STUFF_LIMIT));
            serial_d    = NRZI_EN ? (dataBit ? serial_q : !serial_q) : dataBit;
            stuffing_d  = 1'b0;
            strobe_d    = 1'b1;
            state_d     = DATA;
        end
        if (startStuff) begin
            ones_d      = '0;
            stuffPend_d = 1'b0;
            serial_d    = NRZI_EN ? !serial_q : 1'b0;
            stuffing_d  = 1'b1;
            strobe_d    = 1'b1;
            state_d     = STUFF;
        end
        if (goIdle) begin
            state_d     = IDLE;
            serial_d    = 1'b1;
            ones_d      = '0;
            stuffPend_d = 1'b0;
            stuffing_d  = 1'b0;
            timer_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            pendFull_q  <= 1'b0;
            shift_q     <= '0;
            bitIdx_q    <= '0;
            timer_q     <= '0;
            ones_q      <= '0;
            stuffPend_q <= 1'b0;
            serial_q    <= 1'b1;
            stuffing_q  <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pendFull_q  <= pendFull_d;
            shift_q     <= shift_d;
            bitIdx_q    <= bitIdx_d;
            timer_q     <= timer_d;
            ones_q      <= ones_d;
            stuffPend_q <= stuffPend_d;
            serial_q    <= serial_d;
            stuffing_q  <= stuffing_d;
            strobe_q    <= strobe_d;
        end
    end

    assign data_ready = !pendFull_q;
    assign serial_out = serial_q;
    assign stuffing   = stuffing_q;
    assign bit_strobe = strobe_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bit_stuffer_ser.sv
// Directed bench for bit_stuffer_ser: one raw-line and one NRZI instance share clock and reset,
// each scenario task drives words and compares per-bit-period line behaviour against hand-built tables.
module tb_bit_stuffer_ser;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] data0, data1;
    logic valid0, valid1;
    logic rdy0, ser0, stf0, stb0, busy0;
    logic rdy1, ser1, stf1, stb1, busy1;

    int nTests = 0;
    int nFail  = 0;

    logic capSer [0:199];
    logic capStf [0:199];
    logic capStb [0:199];
    logic capBusy[0:199];
    logic capRdy [0:199];

    always #5 clk = ~clk;

    bit_stuffer_ser #(.DATA_W(8), .BIT_PERIOD(8), .STUFF_LIMIT(6), .NRZI_EN(1'b0)) dutRaw (
        .clk(clk), .rst(rst), .data_in(data0), .data_valid(valid0), .data_ready(rdy0),
        .serial_out(ser0), .stuffing(stf0), .bit_strobe(stb0), .busy(busy0)
    );

    bit_stuffer_ser #(.DATA_W(8), .BIT_PERIOD(8), .STUFF_LIMIT(6), .NRZI_EN(1'b1)) dutNrzi (
        .clk(clk), .rst(rst), .data_in(data1), .data_valid(valid1), .data_ready(rdy1),
        .serial_out(ser1), .stuffing(stf1), .bit_strobe(stb1), .busy(busy1)
    );

    // Records n samples taken 1 time unit after successive rising edges.
    task automatic capture(input bit sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            capSer[i]  = sel ? ser1  : ser0;
            capStf[i]  = sel ? stf1  : stf0;
            capStb[i]  = sel ? stb1  : stb0;
            capBusy[i] = sel ? busy1 : busy0;
            capRdy[i]  = sel ? rdy1  : rdy0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0; data0 = 8'h00; data1 = 8'h00;
        #12;
        nTests++;
        if ({ser0, rdy0, stf0, stb0, busy0} !== 5'b11000) begin
            nFail++;
            $display("[TB] FAIL reset_raw: got ser/rdy/stf/stb/busy=%b, want 11000", {ser0, rdy0, stf0, stb0, busy0});
        end
        nTests++;
        if ({ser1, rdy1, stf1, stb1, busy1} !== 5'b11000) begin
            nFail++;
            $display("[TB] FAIL reset_nrzi: got ser/rdy/stf/stb/busy=%b, want 11000", {ser1, rdy1, stf1, stb1, busy1});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        nTests++;
        if ({ser0, rdy0, busy0, ser1, rdy1, busy1} !== 6'b110110) begin
            nFail++;
            $display("[TB] FAIL reset_release: got %b, want 110110", {ser0, rdy0, busy0, ser1, rdy1, busy1});
        end
    endtask

    task automatic test_serialise();
        bit         tSel  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] tWord [5] = '{8'hD5, 8'hFF, 8'hFC, 8'h00, 8'hFF};
        int         tPer  [5] = '{8, 9, 9, 8, 9};
        logic [8:0] tLine [5] = '{9'h0D5, 9'h1BF, 9'h0FC, 9'h0AA, 9'h03F};
        logic [8:0] tStuff[5] = '{9'h000, 9'h040, 9'h100, 9'h000, 9'h040};
        for (int e = 0; e < 5; e++) begin
            if (tSel[e]) begin data1 = tWord[e]; valid1 = 1'b1; end
            else begin data0 = tWord[e]; valid0 = 1'b1; end
            @(posedge clk); #1;
            valid0 = 1'b0; valid1 = 1'b0;
            nTests++;
            if ((tSel[e] ? {ser1, busy1, rdy1} : {ser0, busy0, rdy0}) !== 3'b100) begin
                nFail++;
                $display("[TB] FAIL serialise%0d_accept: got ser/busy/rdy=%b, want 100",
                         e, tSel[e] ? {ser1, busy1, rdy1} : {ser0, busy0, rdy0});
            end
            capture(tSel[e], tPer[e] * 8 + 2);
            for (int p = 0; p < tPer[e]; p++) begin
                bit bad = 1'b0;
                for (int c = 0; c < 8; c++) begin
                    int k = p * 8 + c;
                    if (capSer[k] !== tLine[e][p] || capStf[k] !== tStuff[e][p] ||
                        capStb[k] !== (c == 0) || capBusy[k] !== 1'b1) bad = 1'b1;
                end
                nTests++;
                if (bad) begin
                    nFail++;
                    $display("[TB] FAIL serialise%0d_bit%0d: got ser=%b stf=%b stb=%b busy=%b, want ser=%b stf=%b stb=1 busy=1 for 8 clocks",
                             e, p, capSer[p*8], capStf[p*8], capStb[p*8], capBusy[p*8], tLine[e][p], tStuff[e][p]);
                end
            end
            nTests++;
            begin
                int k = tPer[e] * 8;
                if ({capSer[k], capBusy[k], capStf[k], capStb[k], capRdy[k]} !== 5'b10001) begin
                    nFail++;
                    $display("[TB] FAIL serialise%0d_idle: got ser/busy/stf/stb/rdy=%b, want 10001",
                             e, {capSer[k], capBusy[k], capStf[k], capStb[k], capRdy[k]});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] expLine  = 18'h3DFBF;
        logic [17:0] expStuff = 18'h02040;
        bit rdyBad = 1'b0;
        data0 = 8'hFF; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        for (int i = 0; i < 146; i++) begin
            @(posedge clk); #1;
            capSer[i] = ser0; capStf[i] = stf0; capStb[i] = stb0; capBusy[i] = busy0; capRdy[i] = rdy0;
            if (i == 10) begin data0 = 8'hFF; valid0 = 1'b1; end
            else if (i == 11) data0 = 8'h00;
            else if (i == 20) valid0 = 1'b0;
        end
        for (int p = 0; p < 18; p++) begin
            bit bad = 1'b0;
            for (int c = 0; c < 8; c++) begin
                int k = p * 8 + c;
                if (capSer[k] !== expLine[p] || capStf[k] !== expStuff[p] ||
                    capStb[k] !== (c == 0) || capBusy[k] !== 1'b1) bad = 1'b1;
            end
            nTests++;
            if (bad) begin
                nFail++;
                $display("[TB] FAIL b2b_bit%0d: got ser=%b stf=%b stb=%b busy=%b, want ser=%b stf=%b stb=1 busy=1",
                         p, capSer[p*8], capStf[p*8], capStb[p*8], capBusy[p*8], expLine[p], expStuff[p]);
            end
        end
        for (int i = 0; i < 146; i++) begin
            if (capRdy[i] !== !(i >= 11 && i < 72)) rdyBad = 1'b1;
        end
        nTests++;
        if (rdyBad) begin
            nFail++;
            $display("[TB] FAIL b2b_ready: got rdy@10=%b @11=%b @71=%b @72=%b, want 1 0 0 1",
                     capRdy[10], capRdy[11], capRdy[71], capRdy[72]);
        end
        nTests++;
        if ({capSer[144], capBusy[144], capStf[144]} !== 3'b100) begin
            nFail++;
            $display("[TB] FAIL b2b_idle: got ser/busy/stf=%b, want 100", {capSer[144], capBusy[144], capStf[144]});
        end
    endtask

    task automatic test_reset_mid_stuff();
        logic [8:0] expLine  = 9'h1BF;
        logic [8:0] expStuff = 9'h040;
        data0 = 8'hFF; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        capture(1'b0, 52);
        nTests++;
        if ({capStf[51], capBusy[51]} !== 2'b11) begin
            nFail++;
            $display("[TB] FAIL midstuff_pre: got stf/busy=%b, want 11", {capStf[51], capBusy[51]});
        end
        rst = 1'b1;
        #1;
        nTests++;
        if ({ser0, stf0, busy0, rdy0, stb0} !== 5'b10010) begin
            nFail++;
            $display("[TB] FAIL midstuff_reset: got ser/stf/busy/rdy/stb=%b, want 10010", {ser0, stf0, busy0, rdy0, stb0});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        data0 = 8'hFF; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        capture(1'b0, 74);
        for (int p = 0; p < 9; p++) begin
            bit bad = 1'b0;
            for (int c = 0; c < 8; c++) begin
                int k = p * 8 + c;
                if (capSer[k] !== expLine[p] || capStf[k] !== expStuff[p] ||
                    capStb[k] !== (c == 0) || capBusy[k] !== 1'b1) bad = 1'b1;
            end
            nTests++;
            if (bad) begin
                nFail++;
                $display("[TB] FAIL postreset_bit%0d: got ser=%b stf=%b stb=%b, want ser=%b stf=%b stb=1",
                         p, capSer[p*8], capStf[p*8], capStb[p*8], expLine[p], expStuff[p]);
            end
        end
        nTests++;
        if ({capSer[72], capBusy[72]} !== 2'b10) begin
            nFail++;
            $display("[TB] FAIL postreset_idle: got ser/busy=%b, want 10", {capSer[72], capBusy[72]});
        end
    endtask

    initial begin
        test_reset();
        test_serialise();
        test_back_to_back();
        test_reset_mid_stuff();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
